// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic array left-edge feeder.
// Holds the feeder FSM encoding and the drain-length helper.
package systolic_pkg;

    localparam int DATA_SIZE_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

    // Cycles needed after the last accept to push it through every lane
    function automatic int drain_cycles(input int rows, input int step,
                                        input int extra);
        return (rows - 1) * step + extra;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Valid/ready input bus carrying one ROWS-wide vector per transfer.
// The producer uses the master view, the feeder the slave view.
interface feeder_in_if #(
    parameter int DATA_SIZE = 32,
    parameter int ROWS      = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*DATA_SIZE-1:0] in_vec;
    logic                      in_last;

    modport master (
        output in_valid,
        output in_vec,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth shift register for one lane (data plus valid bit).
// Depth zero degenerates to a plain wire.
module skew_delay_line #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst_n, clr};
        assign q = d;
    end else begin : g_regs
        logic [DEPTH-1:0][WIDTH-1:0] sr;

        // Shift one stage per clock; clear wipes every stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (clr) begin
                sr <= '0;
            end else begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder: accepts vectors and skews lane r by r*SKEW_STEP.
// After the last vector it drains with zeros and pulses done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEF,
    parameter int ROWS        = 4,
    parameter int SKEW_STEP   = 1,
    parameter int DRAIN_EXTRA = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    feeder_in_if.slave                in_bus,
    input  logic                      flush,
    output logic [ROWS*DATA_SIZE-1:0] out_data,
    output logic [ROWS-1:0]           out_lane_valid,
    output logic                      enable_out,
    output logic                      busy,
    output logic                      done
);
    localparam int D  = drain_cycles(ROWS, SKEW_STEP, DRAIN_EXTRA);
    localparam int CW = $clog2(D + 1);
    localparam int LW = DATA_SIZE + 1;

    feeder_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept;

    logic [ROWS-1:0][LW-1:0] lane_in;
    logic [ROWS-1:0][LW-1:0] lane_q;

    assign in_bus.in_ready = ((state == IDLE) || (state == STREAM)) && !flush;
    assign accept          = in_bus.in_valid && in_bus.in_ready;
    assign busy            = (state != IDLE);

    // Next state, drain count and done pulse
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n   = '0;
                    state_n = in_bus.in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (accept && in_bus.in_last) begin
                    cnt_n   = '0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt == CW'(D - 1)) begin
                    done    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            done    = 1'b0;
        end
    end

    // State, counter and row enable registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            enable_out <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            enable_out <= (state_n != IDLE);
        end
    end

    // Lane entry: accepted element with valid, otherwise a zero bubble
    always_comb begin
        lane_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (accept) begin
                lane_in[r] = {1'b1, in_bus.in_vec[r*DATA_SIZE +: DATA_SIZE]};
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        skew_delay_line #(
            .WIDTH (LW),
            .DEPTH (r * SKEW_STEP)
        ) u_dly (
            .clk   (clk),
            .rst_n (reset),
            .clr   (flush),
            .d     (lane_in[r]),
            .q     (lane_q[r])
        );
    end

    // Registered output stage feeding the PE rows
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data       <= '0;
            out_lane_valid <= '0;
        end else if (flush) begin
            out_data       <= '0;
            out_lane_valid <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                out_data[r*DATA_SIZE +: DATA_SIZE] <= lane_q[r][DATA_SIZE-1:0];
                out_lane_valid[r]                  <= lane_q[r][DATA_SIZE];
            end
        end
    end
endmodule
